exu_ctrl: RTL and testbench
===========================

# exu_ctrl

Multi-cycle sequencer for the NPC execution datapath. It walks each instruction through fetch, decode, execute, memory and write-back, and drives the register and memory enables around the shared ALU. It also runs the instruction-fetch and LSU valid/ready handshakes, watchdog-times memory waits, keeps cycle and retired-instruction counters, and stops the core on `ebreak`, an illegal instruction or a bus timeout.

## Interface
Parameters:
- `CNT_WIDTH`, 64, width of `cycle_cnt` and `instret_cnt`
- `BUS_TIMEOUT`, 255, maximum wait cycles in FETCH or MEM before an error halt

Ports:
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous and active-high
- `inst_num` in `INST_NUM_WIDTH`: decoded instruction number
- `alu_result` in `ISA_WIDTH`: ALU output; bit 0 is the EQ flag for `beq`
- `ifu_req` out 1: instruction fetch request
- `ifu_rvalid` in 1: instruction word valid
- `ir_we` out 1: latch the instruction register
- `alu_we` out 1: latch `alu_result` into the ALU result register
- `lsu_req` out 1: LSU request valid
- `lsu_wen` out 1: LSU store enable
- `lsu_ready` in 1: LSU accepts the request
- `lsu_rvalid` in 1: LSU access complete
- `pc_we` out 1: PC update
- `pc_sel` out 2: next-PC select; 0 = pc+4, 1 = pc+imm, 2 = (src1+imm)&~1
- `gpr_we` out 1: register-file write
- `halt` out 1: core stopped (sticky)
- `halt_err` out 1: the stop was an error (illegal instruction or timeout)
- `cycle_cnt` out `CNT_WIDTH`: cycle counter
- `instret_cnt` out `CNT_WIDTH`: retired-instruction counter

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, MEM_WAIT, WB, HALT.
- Control outputs are combinational from the state and the handshake inputs. Every output is 0 in RESET.
- **RESET:** moves to FETCH on the first clock edge after `rst` falls.
- **FETCH:**
  - `ifu_req`=1.
  - On `ifu_rvalid`: `ir_we`=1, go to DECODE.
- **DECODE:** one cycle.
  - `ebreak` → HALT with `halt_err`=0.
  - `inst_num` outside the supported set (auipc, jal, jalr, beq, sw, lw, addi, add, ebreak) → HALT with `halt_err`=1.
  - Otherwise → EXEC.
- **EXEC:** one cycle, `alu_we`=1.
  - Loads and stores → MEM.
  - Everything else → WB.
- **MEM:**
  - `lsu_req`=1; `lsu_wen`=1 for `sw`.
  - `lsu_ready` and `lsu_rvalid` both high → WB.
  - `lsu_ready` high, `lsu_rvalid` low → MEM_WAIT.
  - `lsu_req` and `lsu_wen` hold steady until `lsu_ready`.
- **MEM_WAIT:** `lsu_req`=0; on `lsu_rvalid` → WB.
- **WB:** one cycle, `pc_we`=1, then FETCH.
  - `gpr_we`=1 for auipc, jal, jalr, addi, add, lw.
  - `pc_sel`: 1 for jal, and for beq when `alu_result[0]`=1; 2 for jalr; 0 otherwise.
  - `instret_cnt` increments.
- **HALT:** `halt`=1, and `halt_err` is held. Only `rst` leaves HALT; all enables stay 0.
- **Watchdog:**
  - Counts consecutive cycles spent in FETCH, or in MEM plus MEM_WAIT.
  - Clears on every state change out of the waiting state.
  - When the count reaches `BUS_TIMEOUT` with the awaited input still low → HALT with `halt_err`=1.
  - A handshake arriving in the same cycle the count reaches `BUS_TIMEOUT` wins; no error.
- **cycle_cnt:** increments in every state except RESET and HALT. Both counters wrap modulo 2^`CNT_WIDTH`.

## Timing
- Non-memory instruction with `ifu_rvalid` in the first FETCH cycle: 4 cycles (FETCH, DECODE, EXEC, WB).
- `sw`/`lw` with `lsu_ready` and `lsu_rvalid` in the same cycle: 5 cycles.
- Each extra wait cycle adds one cycle.
- State, watchdog, counters, `halt` and `halt_err` are registered. Asynchronous `rst` clears all of them immediately, mid-instruction included. No partial write is issued, because enables are combinational from the cleared state.
- `ifu_rvalid` outside FETCH and `lsu_ready`/`lsu_rvalid` outside MEM/MEM_WAIT are ignored.

## Structure
- Shared config header holds:
  - state encodings;
  - `pc_sel` codes (`PC_SNPC`, `PC_IMM`, `PC_JALR`);
  - the `lw` instruction number, alongside the existing instruction numbers.
- Instruction classification (`is_mem`, `is_store`, `writes_rd`, `legal`) is a local combinational decode of `inst_num`.
- Sub-module `ctrl_wdog`: the watchdog counter, with inputs `waiting` and `done` and output `expired`.

## Test plan
- `addi` with `ifu_rvalid` in the first FETCH cycle → `ir_we`, `alu_we`, `pc_we`+`gpr_we` in cycles 1, 3, 4; `pc_sel`=0; `instret_cnt` 0→1; `cycle_cnt`=4.
- `beq` with `alu_result`=1, then `beq` with `alu_result`=0 → `pc_sel`=1 then 0; `gpr_we`=0 both times.
- `sw` with `lsu_ready` after 2 cycles and `lsu_rvalid` 3 cycles later → `lsu_req`/`lsu_wen` high for 3 cycles, then MEM_WAIT; `gpr_we`=0 in WB.
- `ifu_rvalid` held low with `BUS_TIMEOUT`=4 → `halt`=1, `halt_err`=1 after 4 FETCH cycles; `cycle_cnt` frozen afterwards.
- `ebreak` → `halt`=1, `halt_err`=0 after DECODE. An undefined `inst_num` → `halt_err`=1.
- `rst` asserted during MEM → all outputs 0 at once, counters 0; FETCH resumes one cycle after release.

Source files
------------

// File: rtl/exu_ctrl_pkg.sv
// Shared configuration for the NPC execution sequencer: widths, instruction
// numbers, sequencer state encodings and next-PC select codes.
package exu_ctrl_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int INST_NUM_WIDTH = 6;

    // Instruction numbers produced by the decoder. Zero is reserved as "not
    // recognised" so that an unprogrammed decode never looks legal.
    localparam logic [INST_NUM_WIDTH-1:0] INST_INV    = 6'd0;
    localparam logic [INST_NUM_WIDTH-1:0] INST_AUIPC  = 6'd1;
    localparam logic [INST_NUM_WIDTH-1:0] INST_JAL    = 6'd2;
    localparam logic [INST_NUM_WIDTH-1:0] INST_JALR   = 6'd3;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ    = 6'd4;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SW     = 6'd5;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI   = 6'd6;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADD    = 6'd7;
    localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 6'd8;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LW     = 6'd9;

    // Next-PC select codes driven on pc_sel during write-back.
    localparam logic [1:0] PC_SNPC = 2'd0;  // pc + 4
    localparam logic [1:0] PC_IMM  = 2'd1;  // pc + imm
    localparam logic [1:0] PC_JALR = 2'd2;  // (src1 + imm) & ~1

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_MEM_WAIT = 3'd5,
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    // Per-instruction control attributes.
    typedef struct packed {
        logic legal;
        logic is_mem;
        logic is_store;
        logic writes_rd;
        logic is_ebreak;
    } inst_class_t;

    // States in which the sequencer is blocked on an external handshake.
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM) || (st == ST_MEM_WAIT);
    endfunction

endpackage

// File: rtl/exu_ctrl_if.sv
// Instruction-fetch and LSU handshake bundle between the sequencer (master)
// and the fetch/load-store units (slave).
//
// Handshake rules: a request (ifu_req, lsu_req) is a level that the master
// keeps high, with lsu_wen stable, until the slave acknowledges it. The IFU
// acknowledges with ifu_rvalid, which also marks the instruction word valid.
// The LSU accepts with lsu_ready and reports completion with lsu_rvalid;
// both may rise in the same cycle. Once lsu_ready has been seen the request
// drops and the master only waits for lsu_rvalid. Acknowledges seen while
// no request is pending are ignored.
interface exu_ctrl_if;

    logic ifu_req;
    logic ifu_rvalid;
    logic lsu_req;
    logic lsu_wen;
    logic lsu_ready;
    logic lsu_rvalid;

    modport master (
        output ifu_req,
        output lsu_req,
        output lsu_wen,
        input  ifu_rvalid,
        input  lsu_ready,
        input  lsu_rvalid
    );

    modport slave (
        input  ifu_req,
        input  lsu_req,
        input  lsu_wen,
        output ifu_rvalid,
        output lsu_ready,
        output lsu_rvalid
    );

endinterface

// File: rtl/exu_ctrl_wdog.sv
// Bus watchdog: counts consecutive cycles spent waiting on a handshake and
// flags expiry when the limit is reached without the awaited acknowledge.
module ctrl_wdog
    import exu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic done,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // cnt_q holds the number of earlier waiting cycles, so the current cycle
    // is number cnt_q + 1; the limit is reached when cnt_q == TIMEOUT - 1.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while waiting (saturating); any non-waiting cycle clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!waiting) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An acknowledge in the final cycle wins over expiry.
    always_comb begin
        expired = waiting && !done && (cnt_q >= LAST);
    end

endmodule

// File: rtl/exu_ctrl.sv
// Multi-cycle sequencer for the NPC execution datapath: walks each
// instruction through fetch, decode, execute, memory and write-back, drives
// the datapath enables, runs the IFU/LSU handshakes and stops the core on
// ebreak, an illegal instruction or a bus timeout.
module exu_ctrl
    import exu_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 64,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INST_NUM_WIDTH-1:0] inst_num,
    input  logic [ISA_WIDTH-1:0]      alu_result,
    exu_ctrl_if.master                bus,
    output logic                      ir_we,
    output logic                      alu_we,
    output logic                      pc_we,
    output logic [1:0]                pc_sel,
    output logic                      gpr_we,
    output logic                      halt,
    output logic                      halt_err,
    output logic [CNT_WIDTH-1:0]      cycle_cnt,
    output logic [CNT_WIDTH-1:0]      instret_cnt,
    output state_t                    dbg_state
);

    state_t                 state_q, state_d;
    logic                   halt_q, halt_d;
    logic                   halt_err_q, halt_err_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;

    inst_class_t            cls;
    logic                   wd_waiting;
    logic                   wd_done;
    logic                   wd_expired;

    // Only the EQ flag of the ALU result steers the sequencer.
    logic                   unused_alu_bits;
    assign unused_alu_bits = ^alu_result[ISA_WIDTH-1:1];

    // Local decode of the instruction number into control attributes.
    always_comb begin
        cls = '0;
        case (inst_num)
            INST_AUIPC:  begin cls.legal = 1'b1; cls.writes_rd = 1'b1; end
            INST_JAL:    begin cls.legal = 1'b1; cls.writes_rd = 1'b1; end
            INST_JALR:   begin cls.legal = 1'b1; cls.writes_rd = 1'b1; end
            INST_BEQ:    begin cls.legal = 1'b1; end
            INST_SW:     begin cls.legal = 1'b1; cls.is_mem = 1'b1; cls.is_store = 1'b1; end
            INST_LW:     begin cls.legal = 1'b1; cls.is_mem = 1'b1; cls.writes_rd = 1'b1; end
            INST_ADDI:   begin cls.legal = 1'b1; cls.writes_rd = 1'b1; end
            INST_ADD:    begin cls.legal = 1'b1; cls.writes_rd = 1'b1; end
            INST_EBREAK: begin cls.legal = 1'b1; cls.is_ebreak = 1'b1; end
            default:     cls = '0;
        endcase
    end

    // Watchdog feed: which acknowledge the current waiting state expects.
    always_comb begin
        wd_waiting = is_wait_state(state_q);
        case (state_q)
            ST_FETCH:    wd_done = bus.ifu_rvalid;
            ST_MEM:      wd_done = bus.lsu_ready;
            ST_MEM_WAIT: wd_done = bus.lsu_rvalid;
            default:     wd_done = 1'b0;
        endcase
    end

    ctrl_wdog #(
        .TIMEOUT (BUS_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (wd_waiting),
        .done    (wd_done),
        .expired (wd_expired)
    );

    // Next-state, halt cause and counter updates.
    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        halt_err_d = halt_err_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.ifu_rvalid) begin
                    state_d = ST_DECODE;
                end else if (wd_expired) begin
                    state_d    = ST_HALT;
                    halt_d     = 1'b1;
                    halt_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!cls.legal) begin
                    state_d    = ST_HALT;
                    halt_d     = 1'b1;
                    halt_err_d = 1'b1;
                end else if (cls.is_ebreak) begin
                    state_d    = ST_HALT;
                    halt_d     = 1'b1;
                    halt_err_d = 1'b0;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = cls.is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.lsu_ready && bus.lsu_rvalid) begin
                    state_d = ST_WB;
                end else if (bus.lsu_ready) begin
                    state_d = ST_MEM_WAIT;
                end else if (wd_expired) begin
                    state_d    = ST_HALT;
                    halt_d     = 1'b1;
                    halt_err_d = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.lsu_rvalid) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d    = ST_HALT;
                    halt_d     = 1'b1;
                    halt_err_d = 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RESET;
        endcase

        cycle_d = cycle_q;
        if ((state_q != ST_RESET) && (state_q != ST_HALT)) begin
            cycle_d = cycle_q + 1'b1;
        end
        instret_d = instret_q;
        if (state_q == ST_WB) begin
            instret_d = instret_q + 1'b1;
        end
    end

    // Sequencer state, halt status and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RESET;
            halt_q     <= 1'b0;
            halt_err_q <= 1'b0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            halt_err_q <= halt_err_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    // Datapath enables and handshake requests, decoded from the current state.
    always_comb begin
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_wen = 1'b0;
        ir_we       = 1'b0;
        alu_we      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SNPC;
        gpr_we      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.ifu_req = 1'b1;
                ir_we       = bus.ifu_rvalid;
            end
            ST_EXEC: alu_we = 1'b1;
            ST_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_wen = cls.is_store;
            end
            ST_WB: begin
                pc_we  = 1'b1;
                gpr_we = cls.writes_rd;
                if (inst_num == INST_JAL) begin
                    pc_sel = PC_IMM;
                end else if (inst_num == INST_JALR) begin
                    pc_sel = PC_JALR;
                end else if ((inst_num == INST_BEQ) && alu_result[0]) begin
                    pc_sel = PC_IMM;
                end
            end
            default: ;
        endcase
    end

    assign halt        = halt_q;
    assign halt_err    = halt_err_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Bench for exu_ctrl: one main instance for instruction flow and reset, a
// second with a short bus timeout for watchdog behaviour.
module tb_exu_ctrl;
    import exu_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main instance ----------------
    logic                      rst;
    logic [INST_NUM_WIDTH-1:0] inst_num;
    logic [ISA_WIDTH-1:0]      alu_result;
    logic ir_we, alu_we, pc_we, gpr_we, halt, halt_err;
    logic [1:0]  pc_sel;
    logic [63:0] cycle_cnt, instret_cnt;
    state_t      dbg_state;
    exu_ctrl_if  bus();

    exu_ctrl #(.CNT_WIDTH(64), .BUS_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .inst_num(inst_num), .alu_result(alu_result),
        .bus(bus), .ir_we(ir_we), .alu_we(alu_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .gpr_we(gpr_we), .halt(halt), .halt_err(halt_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
    );

    // ---------------- watchdog instance (timeout 4) ----------------
    logic                      w_rst;
    logic [INST_NUM_WIDTH-1:0] w_inst;
    logic [ISA_WIDTH-1:0]      w_alu;
    logic w_ir_we, w_alu_we, w_pc_we, w_gpr_we, w_halt, w_halt_err;
    logic [1:0]  w_pc_sel;
    logic [15:0] w_cycle, w_instret;
    state_t      w_state;
    exu_ctrl_if  bus_w();

    exu_ctrl #(.CNT_WIDTH(16), .BUS_TIMEOUT(4)) dut_wd (
        .clk(clk), .rst(w_rst), .inst_num(w_inst), .alu_result(w_alu),
        .bus(bus_w), .ir_we(w_ir_we), .alu_we(w_alu_we), .pc_we(w_pc_we),
        .pc_sel(w_pc_sel), .gpr_we(w_gpr_we), .halt(w_halt), .halt_err(w_halt_err),
        .cycle_cnt(w_cycle), .instret_cnt(w_instret), .dbg_state(w_state)
    );

    // ---------------- model state ----------------
    logic [2:0] exp_q[$];      // expected {gpr_we, pc_sel} per write-back
    longint m_cyc     = 0;
    longint m_instret = 0;
    int obs_cycles, obs_req, obs_wen, obs_wait, obs_gpr;
    int ir_at, alu_at, pc_at;
    logic [1:0] obs_sel;

    function automatic logic [2:0] exp_wb(input logic [5:0] inst, input logic [31:0] alu);
        logic g;
        logic [1:0] s;
        g = 1'b0;
        s = PC_SNPC;
        case (inst)
            INST_AUIPC, INST_ADDI, INST_ADD, INST_LW: g = 1'b1;
            INST_JAL:  begin g = 1'b1; s = PC_IMM;  end
            INST_JALR: begin g = 1'b1; s = PC_JALR; end
            INST_BEQ:  s = alu[0] ? PC_IMM : PC_SNPC;
            default: ;
        endcase
        return {g, s};
    endfunction

    // ---------------- scoreboard: write-back checker ----------------
    always @(negedge clk) begin
        if (pc_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected got pc_we=1 required no write-back");
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({gpr_we, pc_sel} !== e) begin
                    bad++;
                    $display("FAIL wb_ctrl got gpr_we/pc_sel=%b required=%b", {gpr_we, pc_sel}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock cycle of the main instance: sample outputs, then advance.
    task automatic step();
        #1;
        obs_cycles++;
        if (ir_we && ir_at == 0)  ir_at  = obs_cycles;
        if (alu_we && alu_at == 0) alu_at = obs_cycles;
        if (pc_we && pc_at == 0) begin pc_at = obs_cycles; obs_sel = pc_sel; end
        obs_req  += int'(bus.lsu_req);
        obs_wen  += int'(bus.lsu_wen);
        obs_gpr  += int'(gpr_we);
        obs_wait += int'(dbg_state == ST_MEM_WAIT);
        @(posedge clk);
        #1;
        m_cyc++;
    endtask

    // Run one instruction starting in FETCH; fw/rw/vw are the cycles before
    // ifu_rvalid, before lsu_ready, and from lsu_ready to lsu_rvalid.
    task automatic do_instr(input logic [5:0] inst, input logic [31:0] alu,
                            input int fw, input int rw, input int vw);
        logic mem;
        mem = (inst == INST_SW) || (inst == INST_LW);
        obs_cycles = 0; obs_req = 0; obs_wen = 0; obs_wait = 0; obs_gpr = 0;
        ir_at = 0; alu_at = 0; pc_at = 0; obs_sel = 2'b11;
        exp_q.push_back(exp_wb(inst, alu));
        inst_num   = inst;
        alu_result = alu;
        for (int i = 0; i <= fw; i++) begin
            bus.ifu_rvalid = (i == fw);
            step();
        end
        bus.ifu_rvalid = 1'b0;
        step();                                   // DECODE
        step();                                   // EXEC
        if (mem) begin
            for (int i = 0; i <= rw; i++) begin
                bus.lsu_ready  = (i == rw);
                bus.lsu_rvalid = (i == rw) && (vw == 0);
                step();
            end
            bus.lsu_ready  = 1'b0;
            bus.lsu_rvalid = 1'b0;
            for (int i = 1; i <= vw; i++) begin
                bus.lsu_rvalid = (i == vw);
                step();
            end
            bus.lsu_rvalid = 1'b0;
        end
        step();                                   // WB
        m_instret++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_cyc = 0;
        m_instret = 0;
    endtask

    task automatic wd_reset();
        w_rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.ifu_req, bus.lsu_req, bus.lsu_wen, ir_we, alu_we, pc_we, gpr_we, halt, halt_err, pc_sel} !== 11'b0) begin
            bad++; $display("FAIL reset_outputs got nonzero enables required all 0");
        end
        total++;
        if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0 || dbg_state !== ST_RESET) begin
            bad++; $display("FAIL reset_state got cyc=%0d ret=%0d st=%0d required 0/0/RESET", cycle_cnt, instret_cnt, dbg_state);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dbg_state !== ST_FETCH || bus.ifu_req !== 1'b1 || cycle_cnt !== 64'd0) begin
            bad++; $display("FAIL reset_exit got st=%0d ifu_req=%b cyc=%0d required FETCH/1/0", dbg_state, bus.ifu_req, cycle_cnt);
        end
        m_cyc = 0;
        m_instret = 0;
    endtask

    task automatic test_addi();
        do_instr(INST_ADDI, 32'h5, 0, 0, 0);
        total++;
        if (ir_at != 1 || alu_at != 3 || pc_at != 4) begin
            bad++; $display("FAIL addi_timing got ir/alu/pc at %0d/%0d/%0d required 1/3/4", ir_at, alu_at, pc_at);
        end
        total++;
        if (obs_gpr != 1 || obs_sel !== PC_SNPC) begin
            bad++; $display("FAIL addi_wb got gpr=%0d sel=%0d required 1/0", obs_gpr, obs_sel);
        end
        total++;
        if (cycle_cnt !== 64'd4 || instret_cnt !== 64'd1) begin
            bad++; $display("FAIL addi_counters got cyc=%0d ret=%0d required 4/1", cycle_cnt, instret_cnt);
        end
    endtask

    task automatic test_beq();
        do_instr(INST_BEQ, 32'h1, 0, 0, 0);
        total++;
        if (obs_sel !== PC_IMM || obs_gpr != 0) begin
            bad++; $display("FAIL beq_taken got sel=%0d gpr=%0d required 1/0", obs_sel, obs_gpr);
        end
        do_instr(INST_BEQ, 32'hFFFF_FFFE, 1, 0, 0);
        total++;
        if (obs_sel !== PC_SNPC || obs_gpr != 0) begin
            bad++; $display("FAIL beq_not_taken got sel=%0d gpr=%0d required 0/0", obs_sel, obs_gpr);
        end
    endtask

    task automatic test_sw();
        do_instr(INST_SW, 32'h100, 0, 2, 3);
        total++;
        if (obs_req != 3 || obs_wen != 3 || obs_wait != 3) begin
            bad++; $display("FAIL sw_handshake got req=%0d wen=%0d wait=%0d required 3/3/3", obs_req, obs_wen, obs_wait);
        end
        total++;
        if (obs_gpr != 0 || pc_at != 10) begin
            bad++; $display("FAIL sw_wb got gpr=%0d pc_at=%0d required 0/10", obs_gpr, pc_at);
        end
    endtask

    task automatic test_lw();
        do_instr(INST_LW, 32'h104, 1, 0, 0);
        total++;
        if (obs_req != 1 || obs_wen != 0 || obs_wait != 0 || pc_at != 6) begin
            bad++; $display("FAIL lw_flow got req=%0d wen=%0d wait=%0d pc_at=%0d required 1/0/0/6", obs_req, obs_wen, obs_wait, pc_at);
        end
        total++;
        if (cycle_cnt !== 64'(m_cyc) || instret_cnt !== 64'(m_instret)) begin
            bad++; $display("FAIL lw_counters got cyc=%0d ret=%0d required %0d/%0d", cycle_cnt, instret_cnt, m_cyc, m_instret);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [8];
        ops = '{INST_AUIPC, INST_JAL, INST_JALR, INST_BEQ, INST_SW, INST_LW, INST_ADDI, INST_ADD};
        for (int n = 0; n < 12; n++) begin
            do_instr(ops[$urandom_range(0, 7)], $urandom, $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end
        total++;
        if (cycle_cnt !== 64'(m_cyc) || instret_cnt !== 64'(m_instret)) begin
            bad++; $display("FAIL b2b_counters got cyc=%0d ret=%0d required %0d/%0d", cycle_cnt, instret_cnt, m_cyc, m_instret);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid_mem();
        inst_num = INST_SW;
        bus.ifu_rvalid = 1'b1;
        step();
        bus.ifu_rvalid = 1'b0;
        step();
        step();
        #1;
        total++;
        if (dbg_state !== ST_MEM || bus.lsu_req !== 1'b1 || bus.lsu_wen !== 1'b1) begin
            bad++; $display("FAIL rst_pre_mem got st=%0d req=%b wen=%b required MEM/1/1", dbg_state, bus.lsu_req, bus.lsu_wen);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.ifu_req, bus.lsu_req, bus.lsu_wen, ir_we, alu_we, pc_we, gpr_we, halt, halt_err, pc_sel} !== 11'b0
            || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            bad++; $display("FAIL rst_async got req=%b wen=%b cyc=%0d ret=%0d required all 0", bus.lsu_req, bus.lsu_wen, cycle_cnt, instret_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (dbg_state !== ST_RESET || bus.ifu_req !== 1'b0) begin
            bad++; $display("FAIL rst_release got st=%0d ifu_req=%b required RESET/0", dbg_state, bus.ifu_req);
        end
        @(posedge clk);
        #1;
        total++;
        if (dbg_state !== ST_FETCH || bus.ifu_req !== 1'b1 || cycle_cnt !== 64'd0) begin
            bad++; $display("FAIL rst_resume got st=%0d ifu_req=%b cyc=%0d required FETCH/1/0", dbg_state, bus.ifu_req, cycle_cnt);
        end
        m_cyc = 0;
        m_instret = 0;
    endtask

    task automatic test_halt(input logic [5:0] inst, input logic err, input string name);
        inst_num = inst;
        bus.ifu_rvalid = 1'b1;
        step();
        bus.ifu_rvalid = 1'b0;
        step();
        total++;
        if (halt !== 1'b1 || halt_err !== err || dbg_state !== ST_HALT) begin
            bad++; $display("FAIL %s_halt got halt=%b err=%b st=%0d required 1/%b/HALT", name, halt, halt_err, dbg_state, err);
        end
        bus.ifu_rvalid = 1'b1;
        bus.lsu_ready  = 1'b1;
        bus.lsu_rvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.ifu_req, bus.lsu_req, ir_we, alu_we, pc_we, gpr_we} !== 6'b0 || halt !== 1'b1
            || halt_err !== err || cycle_cnt !== 64'(m_cyc)) begin
            bad++; $display("FAIL %s_sticky got halt=%b err=%b cyc=%0d required 1/%b/%0d, enables 0", name, halt, halt_err, cycle_cnt, err, m_cyc);
        end
        bus.ifu_rvalid = 1'b0;
        bus.lsu_ready  = 1'b0;
        bus.lsu_rvalid = 1'b0;
        do_reset();
    endtask

    task automatic test_timeout_fetch();
        w_inst = INST_ADDI;
        bus_w.ifu_rvalid = 1'b0;
        wd_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (w_state !== ST_FETCH || w_halt !== 1'b0) begin
            bad++; $display("FAIL wd_fetch_early got st=%0d halt=%b required FETCH/0", w_state, w_halt);
        end
        @(posedge clk);
        #1;
        total++;
        if (w_halt !== 1'b1 || w_halt_err !== 1'b1 || w_cycle !== 16'd4) begin
            bad++; $display("FAIL wd_fetch_expire got halt=%b err=%b cyc=%0d required 1/1/4", w_halt, w_halt_err, w_cycle);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (w_cycle !== 16'd4 || bus_w.ifu_req !== 1'b0) begin
            bad++; $display("FAIL wd_frozen got cyc=%0d ifu_req=%b required 4/0", w_cycle, bus_w.ifu_req);
        end
    endtask

    task automatic test_timeout_boundary();
        w_inst = INST_ADDI;
        wd_reset();
        repeat (3) @(posedge clk);
        #1;
        bus_w.ifu_rvalid = 1'b1;
        @(posedge clk);
        #1;
        bus_w.ifu_rvalid = 1'b0;
        total++;
        if (w_state !== ST_DECODE || w_halt !== 1'b0) begin
            bad++; $display("FAIL wd_boundary got st=%0d halt=%b required DECODE/0", w_state, w_halt);
        end
    endtask

    task automatic test_timeout_mem();
        for (int part = 0; part < 2; part++) begin
            w_inst = INST_LW;
            wd_reset();
            bus_w.ifu_rvalid = 1'b1;
            @(posedge clk);
            #1;
            bus_w.ifu_rvalid = 1'b0;
            repeat (2) @(posedge clk);          // DECODE, EXEC
            #1;
            if (part == 1) begin
                @(posedge clk);                 // MEM cycle 1, ready low
                #1;
                bus_w.lsu_ready = 1'b1;         // MEM cycle 2, accept only
                @(posedge clk);
                #1;
                bus_w.lsu_ready = 1'b0;
                @(posedge clk);                 // MEM_WAIT cycle 3
                #1;
            end else begin
                repeat (3) @(posedge clk);      // MEM cycles 1..3
                #1;
            end
            total++;
            if (w_state !== (part == 1 ? ST_MEM_WAIT : ST_MEM) || w_halt !== 1'b0) begin
                bad++; $display("FAIL wd_mem_early part=%0d got st=%0d halt=%b required wait state/0", part, w_state, w_halt);
            end
            @(posedge clk);
            #1;
            total++;
            if (w_state !== ST_HALT || w_halt_err !== 1'b1) begin
                bad++; $display("FAIL wd_mem_expire part=%0d got st=%0d err=%b required HALT/1", part, w_state, w_halt_err);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; inst_num = INST_INV; alu_result = '0;
        bus.ifu_rvalid = 1'b0; bus.lsu_ready = 1'b0; bus.lsu_rvalid = 1'b0;
        w_rst = 1'b1; w_inst = INST_INV; w_alu = '0;
        bus_w.ifu_rvalid = 1'b0; bus_w.lsu_ready = 1'b0; bus_w.lsu_rvalid = 1'b0;

        test_reset();
        test_addi();
        test_beq();
        test_sw();
        test_lw();
        test_back_to_back();
        test_rst_mid_mem();
        test_halt(INST_EBREAK, 1'b0, "ebreak");
        test_halt(6'd42, 1'b1, "illegal");
        test_timeout_fetch();
        test_timeout_boundary();
        test_timeout_mem();

        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_final got pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got still running required finished");
        $fatal(1, "bench time limit");
    end

endmodule
